// File: rtl/instruction_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_prefetch_buffer_pkg
// Description : Shared types and constants for the instruction prefetcher.
//               uint32_t        - 32-bit word/address type
//               PREFETCH_WORD_BYTES - byte stride between consecutive words
//               word_align()    - forces an address onto a word boundary
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_prefetch_buffer_pkg;

    typedef logic [31:0] uint32_t;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PREFETCH_WORD_BYTES = 4;

    // Every memory read fetches a full word.
    localparam logic [3:0] PREFETCH_BYTEENABLE = 4'hF;

    // Byte-offset bits of a CPU address carry no meaning for word fetches.
    function automatic uint32_t word_align(input uint32_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : instruction_prefetch_buffer_pkg
`default_nettype wire

// File: rtl/instruction_prefetch_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Synchronous DEPTH x 32 FIFO holding prefetched instruction
//               words. Push and pop may happen in the same cycle; flush wins
//               over a simultaneous push.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush_i         - empty the FIFO at the next edge
//               push_i/push_data_i - write one word
//               pop_i           - discard the head word
//               count_o         - current occupancy (0..DEPTH)
//               head_data_o     - word at the head (valid when count_o > 0)
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [31:0]              push_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              head_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

endmodule : prefetch_fifo
`default_nettype wire

// File: rtl/instruction_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_prefetch_buffer
// Description : Sequential instruction prefetcher between an Avalon-MM
//               instruction host (CPU side) and the instruction memory bus.
//               Streams consecutive words ahead of the CPU into a small FIFO
//               and flushes/restarts the stream on a non-sequential request.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               cpu_address/cpu_read  - CPU word fetch request
//               cpu_waitrequest       - combinational stall to the CPU
//               cpu_readdata/valid    - returned instruction, 1 cycle after hit
//               mem_address/mem_read  - registered memory read request
//               mem_byteenable        - always all bytes
//               mem_waitrequest       - memory stall
//               mem_readdata/valid    - in-order memory responses
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_prefetch_buffer
    import instruction_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    output logic        cpu_waitrequest,
    output logic [31:0] cpu_readdata,
    output logic        cpu_readdatavalid,

    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid
);

    localparam int      CW       = $clog2(DEPTH) + 1;
    // Headroom so the occupancy sum can never wrap before the compare.
    localparam int      SW       = CW + 2;
    localparam logic [SW-1:0] DEPTH_S  = SW'(DEPTH);
    localparam uint32_t WORD_INC = uint32_t'(PREFETCH_WORD_BYTES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    uint32_t       head_addr_q, head_addr_d;
    uint32_t       fill_addr_q, fill_addr_d;
    logic [CW-1:0] pending_q,   pending_d;
    logic [CW-1:0] discard_q,   discard_d;
    logic          mem_read_q,  mem_read_d;
    uint32_t       mem_address_q, mem_address_d;
    uint32_t       rdata_q,     rdata_d;
    logic          rvalid_q,    rvalid_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [CW-1:0] fifo_count;
    uint32_t       fifo_head;

    logic          addr_match;
    logic          mem_held;
    logic          mem_accept;
    logic          hit;
    logic          redirect;
    logic          rsp_keep;
    logic          rsp_drop;
    logic [CW-1:0] pending_after_rsp;
    logic [CW-1:0] discard_after_rsp;
    logic [CW-1:0] count_next;
    logic [SW-1:0] occupancy_next;
    uint32_t       target_addr;

    // Byte-offset bits of the CPU address are deliberately ignored.
    logic [1:0]    w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = cpu_address[1:0];

    assign addr_match  = (cpu_address[31:2] == head_addr_q[31:2]);
    assign mem_held    = mem_read_q && mem_waitrequest;
    assign mem_accept  = mem_read_q && !mem_waitrequest;
    assign hit         = cpu_read && addr_match && (fifo_count != '0);
    // A held request must keep its address, so a redirect waits until the
    // memory takes it; that read then counts as stale.
    assign redirect    = cpu_read && !addr_match && !mem_held;
    assign rsp_drop    = mem_readdatavalid && (discard_q != '0);
    assign rsp_keep    = mem_readdatavalid && (discard_q == '0);
    assign target_addr = word_align(cpu_address);

    always_comb begin
        pending_after_rsp = pending_q - CW'(rsp_keep);
        discard_after_rsp = discard_q - CW'(rsp_drop);

        count_next    = fifo_count;
        pending_d     = pending_q;
        discard_d     = discard_q;
        head_addr_d   = head_addr_q;
        fill_addr_d   = fill_addr_q;
        mem_read_d    = 1'b0;
        mem_address_d = mem_address_q;
        rvalid_d      = hit;
        rdata_d       = hit ? fifo_head : rdata_q;

        if (redirect) begin
            // Everything already in flight becomes stale, including a read
            // the memory accepts in this very cycle.
            count_next  = '0;
            pending_d   = '0;
            discard_d   = discard_after_rsp + pending_after_rsp + CW'(mem_accept);
            head_addr_d = target_addr;
            fill_addr_d = target_addr;
        end else begin
            count_next  = fifo_count + CW'(rsp_keep) - CW'(hit);
            pending_d   = pending_after_rsp + CW'(mem_accept);
            discard_d   = discard_after_rsp;
            if (hit) begin
                head_addr_d = head_addr_q + WORD_INC;
            end
            if (mem_accept) begin
                fill_addr_d = fill_addr_q + WORD_INC;
            end
        end

        // Budget covers buffered, kept, stale and the read about to issue.
        occupancy_next = SW'(count_next) + SW'(pending_d) + SW'(discard_d);

        if (mem_held) begin
            mem_read_d    = 1'b1;
            mem_address_d = mem_address_q;
        end else if (occupancy_next < DEPTH_S) begin
            mem_read_d    = 1'b1;
            mem_address_d = fill_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_addr_q   <= RESET_PC;
            fill_addr_q   <= RESET_PC;
            pending_q     <= '0;
            discard_q     <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            head_addr_q   <= head_addr_d;
            fill_addr_q   <= fill_addr_d;
            pending_q     <= pending_d;
            discard_q     <= discard_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Word buffer
    // ------------------------------------------------------------------
    prefetch_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (rsp_keep),
        .push_data_i (mem_readdata),
        .pop_i       (hit),
        .count_o     (fifo_count),
        .head_data_o (fifo_head)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_waitrequest   = rst || !hit;
    assign cpu_readdata      = rdata_q;
    assign cpu_readdatavalid = rvalid_q;
    assign mem_address       = mem_address_q;
    assign mem_read          = mem_read_q;
    assign mem_byteenable    = PREFETCH_BYTEENABLE;

endmodule : instruction_prefetch_buffer
`default_nettype wire

// File: tb/tb_instruction_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_prefetch_buffer
// Description : Directed self-checking bench for instruction_prefetch_buffer
//               with an in-order memory model of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    int total = 0;
    int bad   = 0;

    instruction_prefetch_buffer #(
        .DEPTH             (DEPTH),
        .RESET_PC          (RESET_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory model: in-order, fixed latency, responses cleared by reset
    // ------------------------------------------------------------------
    int          lat   = 1;
    int          cyc   = 0;
    logic        stall = 1'b0;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] issued [$];
    logic [31:0] rx     [$];
    int          rx_cyc [$];

    assign mem_waitrequest = stall;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            q_addr.delete();
            q_due.delete();
            mem_readdatavalid = 1'b0;
            mem_readdata      = '0;
        end else begin
            mem_readdatavalid = 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = memword(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (mem_read && !mem_waitrequest) begin
                q_addr.push_back(mem_address);
                q_due.push_back(cyc + lat);
                issued.push_back(mem_address);
            end
        end
        if (cpu_readdatavalid) begin
            rx.push_back(cpu_readdata);
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds cpu_read until accepted (bounded); returns stall cycles seen.
    task automatic fetch(input logic [31:0] a, output bit ok, output int waited);
        ok          = 1'b0;
        waited      = 0;
        cpu_read    = 1'b1;
        cpu_address = a;
        for (int n = 0; n < 64; n++) begin
            #1;
            if (!cpu_waitrequest) begin
                ok = 1'b1;
                break;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        cpu_read = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; cpu_read = 1'b1; cpu_address = 32'h100; stall = 1'b0;
        idle(3);
        issued.delete(); rx.delete(); rx_cyc.delete();
        #1;
        total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq: got %b want 1", cpu_waitrequest); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
        total++; if (cpu_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", cpu_readdatavalid); end
        total++; if (cpu_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", cpu_readdata); end
        total++; if (mem_byteenable !== 4'hF) begin bad++; $display("FAIL byteenable: got %h want f", mem_byteenable); end
        rst = 1'b0; cpu_read = 1'b0;
        tick();
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL first_issue_read: got %b want 1", mem_read); end
        total++; if (mem_address !== RESET_PC) begin bad++; $display("FAIL first_issue_addr: got %h want %h", mem_address, RESET_PC); end
    endtask

    task automatic test_sequential();
        bit ok; int w;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = RESET_PC + 32'(4 * i);
            fetch(a, ok, w);
            total++; if (!ok) begin bad++; $display("FAIL seq_accept[%0d]: got timeout want accept", i); end
        end
        idle(2);
        total++;
        if (rx.size() != 3) begin
            bad++; $display("FAIL seq_count: got %0d words want 3", rx.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                a = RESET_PC + 32'(4 * i);
                total++; if (rx[i] !== memword(a)) begin bad++; $display("FAIL seq_word[%0d]: got %h want %h", i, rx[i], memword(a)); end
            end
            total++; if (rx_cyc[2] - rx_cyc[1] != 1 || rx_cyc[1] - rx_cyc[0] != 1) begin
                bad++; $display("FAIL seq_rate: got cycles %0d %0d %0d want consecutive", rx_cyc[0], rx_cyc[1], rx_cyc[2]);
            end
        end
        total++;
        if (issued.size() < 3) begin
            bad++; $display("FAIL seq_issue_count: got %0d want >=3", issued.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                a = RESET_PC + 32'(4 * i);
                total++; if (issued[i] !== a) begin bad++; $display("FAIL seq_issue[%0d]: got %h want %h", i, issued[i], a); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int w;
        logic [31:0] a;
        idle(8);
        rx.delete(); rx_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            a = 32'h10C + 32'(4 * i);
            fetch(a, ok, w);
            total++; if (!ok || w != 0) begin bad++; $display("FAIL b2b_hit[%0d]: got ok=%0d waits=%0d want ok=1 waits=0", i, ok, w); end
        end
        idle(1);
        total++;
        if (rx.size() != 4) begin
            bad++; $display("FAIL b2b_count: got %0d want 4", rx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                a = 32'h10C + 32'(4 * i);
                total++; if (rx[i] !== memword(a)) begin bad++; $display("FAIL b2b_word[%0d]: got %h want %h", i, rx[i], memword(a)); end
            end
            total++; if (rx_cyc[3] - rx_cyc[0] != 3) begin bad++; $display("FAIL b2b_rate: got span %0d want 3", rx_cyc[3] - rx_cyc[0]); end
        end
    endtask

    task automatic test_budget();
        bit ok; int w;
        lat = 1;
        rst = 1'b1; idle(2); rst = 1'b0;
        issued.delete(); rx.delete(); rx_cyc.delete();
        idle(20);
        total++; if (issued.size() != 4) begin bad++; $display("FAIL budget_fill: got %0d reads want 4", issued.size()); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL budget_idle_read: got %b want 0", mem_read); end
        fetch(32'h100, ok, w);
        total++; if (!ok || w != 0) begin bad++; $display("FAIL budget_hit: got ok=%0d waits=%0d want ok=1 waits=0", ok, w); end
        idle(10);
        total++;
        if (issued.size() != 5) begin
            bad++; $display("FAIL budget_refill: got %0d reads want 5", issued.size());
        end else begin
            total++; if (issued[4] !== 32'h110) begin bad++; $display("FAIL budget_refill_addr: got %h want 110", issued[4]); end
        end
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL budget_refill_idle: got %b want 0", mem_read); end
    endtask

    task automatic test_redirect();
        bit ok; int w;
        lat = 8;
        issued.delete();
        // One-cycle request starts a stream at 0x200, then CPU goes quiet.
        cpu_read = 1'b1; cpu_address = 32'h200;
        tick();
        cpu_read = 1'b0;
        idle(3);
        total++; if (q_addr.size() != 3) begin bad++; $display("FAIL redir_outstanding: got %0d want 3", q_addr.size()); end
        rx.delete(); rx_cyc.delete();
        fetch(32'h400, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL redir_accept400: got timeout want accept"); end
        fetch(32'h404, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL redir_accept404: got timeout want accept"); end
        idle(1);
        total++;
        if (rx.size() != 2) begin
            bad++; $display("FAIL redir_count: got %0d want 2", rx.size());
        end else begin
            total++; if (rx[0] !== memword(32'h400)) begin bad++; $display("FAIL redir_word0: got %h want %h", rx[0], memword(32'h400)); end
            total++; if (rx[1] !== memword(32'h404)) begin bad++; $display("FAIL redir_word1: got %h want %h", rx[1], memword(32'h404)); end
        end
        total++;
        if (issued.size() < 6) begin
            bad++; $display("FAIL redir_issue_count: got %0d want >=6", issued.size());
        end else begin
            total++; if (issued[3] !== 32'h20C || issued[4] !== 32'h400 || issued[5] !== 32'h404) begin
                bad++; $display("FAIL redir_issue_seq: got %h %h %h want 20c 400 404", issued[3], issued[4], issued[5]);
            end
        end
        idle(12);
        total++; if (dut.discard_q !== '0) begin bad++; $display("FAIL redir_discard_zero: got %0d want 0", dut.discard_q); end
    endtask

    task automatic test_blocked_redirect();
        bit ok; int w;
        lat = 1;
        rst = 1'b1; tick();
        issued.delete();
        rst = 1'b0;
        tick();
        tick();
        total++; if (mem_read !== 1'b1 || mem_address !== 32'h104) begin
            bad++; $display("FAIL block_setup: got read=%b addr=%h want 1 104", mem_read, mem_address);
        end
        stall = 1'b1; cpu_read = 1'b1; cpu_address = 32'h800;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL block_waitreq[%0d]: got %b want 1", i, cpu_waitrequest); end
            total++; if (mem_read !== 1'b1 || mem_address !== 32'h104) begin
                bad++; $display("FAIL block_hold[%0d]: got read=%b addr=%h want 1 104", i, mem_read, mem_address);
            end
            tick();
        end
        stall = 1'b0;
        tick();
        total++; if (mem_read !== 1'b1 || mem_address !== 32'h800) begin
            bad++; $display("FAIL block_next_req: got read=%b addr=%h want 1 800", mem_read, mem_address);
        end
        rx.delete(); rx_cyc.delete();
        fetch(32'h800, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL block_accept800: got timeout want accept"); end
        fetch(32'h804, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL block_accept804: got timeout want accept"); end
        idle(1);
        total++;
        if (rx.size() != 2) begin
            bad++; $display("FAIL block_count: got %0d want 2", rx.size());
        end else begin
            total++; if (rx[0] !== memword(32'h800) || rx[1] !== memword(32'h804)) begin
                bad++; $display("FAIL block_words: got %h %h want %h %h", rx[0], rx[1], memword(32'h800), memword(32'h804));
            end
        end
        total++; if (issued.size() < 3 || issued[1] !== 32'h104 || issued[2] !== 32'h800) begin
            bad++; $display("FAIL block_issue_seq: got size=%0d want 104 then 800", issued.size());
        end
    endtask

    task automatic test_wrap();
        bit ok; int w;
        logic [31:0] a [3];
        a[0] = 32'hFFFF_FFF8; a[1] = 32'hFFFF_FFFC; a[2] = 32'h0000_0000;
        lat = 1;
        idle(4);
        issued.delete(); rx.delete(); rx_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            fetch(a[i], ok, w);
            total++; if (!ok) begin bad++; $display("FAIL wrap_accept[%0d]: got timeout want accept", i); end
        end
        idle(1);
        total++;
        if (rx.size() != 3 || issued.size() < 3) begin
            bad++; $display("FAIL wrap_count: got rx=%0d issued=%0d want 3 >=3", rx.size(), issued.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (rx[i] !== memword(a[i])) begin bad++; $display("FAIL wrap_word[%0d]: got %h want %h", i, rx[i], memword(a[i])); end
                total++; if (issued[i] !== a[i]) begin bad++; $display("FAIL wrap_issue[%0d]: got %h want %h", i, issued[i], a[i]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit ok; int w;
        lat = 4;
        fetch(32'h300, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL mid_accept300: got timeout want accept"); end
        total++; if (q_addr.size() < 2) begin bad++; $display("FAIL mid_outstanding: got %0d want >=2", q_addr.size()); end
        rst = 1'b1; cpu_read = 1'b1; cpu_address = 32'h100; lat = 1;
        tick();
        #1;
        total++; if (mem_read !== 1'b0 || mem_address !== 32'h0) begin
            bad++; $display("FAIL mid_reset_mem: got read=%b addr=%h want 0 0", mem_read, mem_address);
        end
        total++; if (cpu_readdatavalid !== 1'b0 || cpu_readdata !== 32'h0) begin
            bad++; $display("FAIL mid_reset_cpu: got valid=%b data=%h want 0 0", cpu_readdatavalid, cpu_readdata);
        end
        total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_reset_waitreq: got %b want 1", cpu_waitrequest); end
        rst = 1'b0;
        issued.delete(); rx.delete(); rx_cyc.delete();
        fetch(32'h100, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL mid_restart_accept: got timeout want accept"); end
        idle(1);
        total++;
        if (rx.size() != 1 || issued.size() < 1) begin
            bad++; $display("FAIL mid_restart_count: got rx=%0d issued=%0d want 1 >=1", rx.size(), issued.size());
        end else begin
            total++; if (issued[0] !== RESET_PC) begin bad++; $display("FAIL mid_restart_addr: got %h want %h", issued[0], RESET_PC); end
            total++; if (rx[0] !== memword(RESET_PC)) begin bad++; $display("FAIL mid_restart_word: got %h want %h", rx[0], memword(RESET_PC)); end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        rst         = 1'b1;
        cpu_read    = 1'b0;
        cpu_address = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_back_to_back();
        test_budget();
        test_redirect();
        test_blocked_redirect();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_prefetch_buffer
`default_nettype wire
